// File: rtl/exc_pipe_pkg.sv
// Shared definitions for the exception-tracking pipeline.
// Holds the CP0 Cause.ExcCode values used by the pipeline and a small
// helper for the fetch-side word-alignment check.
package exc_pipe_pkg;

  localparam int EXC_INT  = 0;   // interrupt
  localparam int EXC_ADEL = 4;   // address error on load / instruction fetch
  localparam int EXC_ADES = 5;   // address error on store
  localparam int EXC_RI   = 10;  // reserved instruction
  localparam int EXC_OV   = 12;  // arithmetic overflow

  localparam int REC_V_W  = 1;
  localparam int REC_EV_W = 1;
  localparam int REC_BD_W = 1;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// One exception-record pipeline register.
// Holds (v, ev, code, bd, pc). Priority on the clock edge:
// flush > hold > bubble > load. The merged outputs fold in this stage's
// own detection unless the record already carries an older exception.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_flush               load a bubble regardless of hold
//   i_hold                keep the current record
//   i_bubble              load an all-zero record (upstream is holding)
//   i_v..i_pc             incoming record
//   i_det_v, i_det_code   exception detected by this stage this cycle
//   o_v..o_pc             merged view of the stored record
module exc_stage_reg
  import exc_pipe_pkg::*;
#(
  parameter int CODE_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_v,
  input  logic              i_ev,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_bd,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_det_v,
  input  logic [CODE_W-1:0] i_det_code,
  output logic              o_v,
  output logic              o_ev,
  output logic [CODE_W-1:0] o_code,
  output logic              o_bd,
  output logic [PC_W-1:0]   o_pc
);

  logic [REC_V_W-1:0]  r_v;
  logic [REC_EV_W-1:0] r_ev;
  logic [CODE_W-1:0]   r_code;
  logic [REC_BD_W-1:0] r_bd;
  logic [PC_W-1:0]     r_pc;
  logic                w_take;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v    <= '0;
      r_ev   <= '0;
      r_code <= '0;
      r_bd   <= '0;
      r_pc   <= '0;
    end else if (i_flush || (!i_hold && i_bubble)) begin
      r_v    <= '0;
      r_ev   <= '0;
      r_code <= '0;
      r_bd   <= '0;
      r_pc   <= '0;
    end else if (!i_hold) begin
      r_v    <= i_v;
      r_ev   <= i_ev;
      r_code <= i_code;
      r_bd   <= i_bd;
      r_pc   <= i_pc;
    end
  end

  // An older exception already in the record always wins over a new detection.
  assign w_take = r_v & ~r_ev & i_det_v;

  assign o_v    = r_v;
  assign o_ev   = r_ev | w_take;
  assign o_code = w_take ? i_det_code : r_code;
  assign o_bd   = r_bd;
  assign o_pc   = r_pc;

endmodule

// File: rtl/exc_pipe.sv
// Exception-tracking record pipeline (top).
// Carries one exception record per instruction through NS stages, lets each
// stage inject a detected exception (oldest wins) and presents a precise
// commit-time exception request with EPC from the last stage.
// Ports:
//   i_clk, i_reset_n        clock, async active-low reset
//   i_flush                 drop every record next edge
//   i_stall[NS]             stage i must hold
//   i_f_*                   fetch record (valid, pc, bd, exception, code)
//   i_det_v, i_det_code     per-stage detections, code i at [i*CODE_W +: CODE_W]
//   i_int_req               pending unmasked interrupt
//   o_cmt_*                 commit view of stage NS-1
//   o_exc_cnt               saturating count of taken exceptions
module exc_pipe
  import exc_pipe_pkg::*;
#(
  parameter int NS     = 4,
  parameter int CODE_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_flush,
  input  logic [NS-1:0]        i_stall,
  input  logic                 i_f_valid,
  input  logic [PC_W-1:0]      i_f_pc,
  input  logic                 i_f_bd,
  input  logic                 i_f_exc_v,
  input  logic [CODE_W-1:0]    i_f_code,
  input  logic [NS-1:0]        i_det_v,
  input  logic [NS*CODE_W-1:0] i_det_code,
  input  logic                 i_int_req,
  output logic                 o_cmt_valid,
  output logic                 o_cmt_exc,
  output logic [CODE_W-1:0]    o_cmt_code,
  output logic                 o_cmt_bd,
  output logic [PC_W-1:0]      o_cmt_epc,
  output logic [CNT_W-1:0]     o_exc_cnt
);

  logic [NS-1:0]     w_hold;
  logic              w_f_ev;
  logic [CODE_W-1:0] w_f_code;

  logic              w_src_v    [NS];
  logic              w_src_ev   [NS];
  logic [CODE_W-1:0] w_src_code [NS];
  logic              w_src_bd   [NS];
  logic [PC_W-1:0]   w_src_pc   [NS];
  logic              w_bubble   [NS];

  logic              w_m_v    [NS];
  logic              w_m_ev   [NS];
  logic [CODE_W-1:0] w_m_code [NS];
  logic              w_m_bd   [NS];
  logic [PC_W-1:0]   w_m_pc   [NS];

  logic              w_exc;
  logic [CNT_W-1:0]  r_exc_cnt;

  // A misaligned fetch is an AdEL regardless of what fetch reported.
  assign w_f_ev   = (i_f_valid && pc_misaligned(i_f_pc[1:0])) ? 1'b1 : i_f_exc_v;
  assign w_f_code = (i_f_valid && pc_misaligned(i_f_pc[1:0])) ? CODE_W'(EXC_ADEL) : i_f_code;

  for (genvar g = 0; g < NS; g++) begin : g_stage
    // A stall anywhere downstream freezes this stage too.
    assign w_hold[g] = |i_stall[NS-1:g];

    if (g == 0) begin : g_fetch
      assign w_src_v[g]    = i_f_valid;
      assign w_src_ev[g]   = w_f_ev;
      assign w_src_code[g] = w_f_code;
      assign w_src_bd[g]   = i_f_bd;
      assign w_src_pc[g]   = i_f_pc;
      assign w_bubble[g]   = 1'b0;
    end else begin : g_chain
      assign w_src_v[g]    = w_m_v[g-1];
      assign w_src_ev[g]   = w_m_ev[g-1];
      assign w_src_code[g] = w_m_code[g-1];
      assign w_src_bd[g]   = w_m_bd[g-1];
      assign w_src_pc[g]   = w_m_pc[g-1];
      assign w_bubble[g]   = w_hold[g-1];
    end

    exc_stage_reg #(
      .CODE_W (CODE_W),
      .PC_W   (PC_W)
    ) u_stage (
      .i_clk      (i_clk),
      .i_rst_n    (i_reset_n),
      .i_flush    (i_flush),
      .i_hold     (w_hold[g]),
      .i_bubble   (w_bubble[g]),
      .i_v        (w_src_v[g]),
      .i_ev       (w_src_ev[g]),
      .i_code     (w_src_code[g]),
      .i_bd       (w_src_bd[g]),
      .i_pc       (w_src_pc[g]),
      .i_det_v    (i_det_v[g]),
      .i_det_code (i_det_code[g*CODE_W +: CODE_W]),
      .o_v        (w_m_v[g]),
      .o_ev       (w_m_ev[g]),
      .o_code     (w_m_code[g]),
      .o_bd       (w_m_bd[g]),
      .o_pc       (w_m_pc[g])
    );
  end

  // Bubbles never raise anything, not even a pending interrupt.
  assign w_exc       = w_m_v[NS-1] & (w_m_ev[NS-1] | i_int_req);
  assign o_cmt_valid = w_m_v[NS-1];
  assign o_cmt_exc   = w_exc;
  assign o_cmt_code  = w_m_ev[NS-1] ? w_m_code[NS-1] : CODE_W'(EXC_INT);
  assign o_cmt_bd    = w_m_bd[NS-1];
  assign o_cmt_epc   = w_m_bd[NS-1] ? (w_m_pc[NS-1] - PC_W'(4)) : w_m_pc[NS-1];

  // Counted only when the commit stage actually moves on, so a held
  // exception is counted once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_exc_cnt <= '0;
    end else if (w_exc && !i_stall[NS-1] && (r_exc_cnt != '1)) begin
      r_exc_cnt <= r_exc_cnt + CNT_W'(1);
    end
  end

  assign o_exc_cnt = r_exc_cnt;

endmodule

// File: doc/exc_pipe.md
Name: exc_pipe

Overview:
- Parametrised exception-tracking pipeline for the MIPS core.
- Carries a per-instruction exception record (valid, code, branch-delay flag, PC) from fetch through NS pipeline registers.
- Each stage can inject its own detected exception code; the oldest exception wins.
- At the last stage it presents one precise commit-time exception request, with EPC, to CP0.
- Generalises the single-stage decode RI check into an N-stage, stall/flush-aware record pipeline with interrupt insertion and statistics.

Parameters:
- NS, 4, number of pipeline record registers (stage 0 = D ... stage NS-1 = commit/W); legal range 2..8.
- CODE_W, 5, exception code width (CP0 Cause.ExcCode).
- PC_W, 32, PC width.
- CNT_W, 16, width of the committed-exception counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  clear all records (exception/eret redirect).
- stall  in  NS  stall[i]=1: stage i must hold.
- f_valid  in  1  fetch presents an instruction.
- f_pc  in  PC_W  fetch PC.
- f_bd  in  1  instruction is in a branch-delay slot.
- f_exc_v  in  1  fetch-detected exception.
- f_code  in  CODE_W  fetch exception code.
- det_v  in  NS  det_v[i]: stage i detected an exception this cycle.
- det_code  in  NS*CODE_W  code for stage i at bits [i*CODE_W +: CODE_W].
- int_req  in  1  pending, unmasked interrupt from CP0.
- cmt_valid  out  1  stage NS-1 holds a real instruction.
- cmt_exc  out  1  exception taken at commit this cycle.
- cmt_code  out  CODE_W  code of the taken exception.
- cmt_bd  out  1  BD flag for Cause.BD.
- cmt_epc  out  PC_W  EPC value.
- exc_cnt  out  CNT_W  saturating count of taken exceptions.

Behaviour:
- Record per stage: v, ev, code, bd, pc. On reset all fields are 0, exc_cnt=0, and all outputs are 0.
- Stage 0 fetch check: if f_valid and f_pc[1:0]!=0, the record gets ev=1 and code=`exc_adel` (4); this overrides f_code. Otherwise ev=f_exc_v and code=f_code.
- Merge at stage i (combinational): if the record already has ev=1, keep it. Else, if v and det_v[i], set ev=1 and code=det_code[i]. Else ev stays 0. The oldest exception always wins; later detections are ignored.
- Hold rule: hold_i = OR of stall[NS-1:i].
  - hold_i=1: register i keeps its value.
  - hold_i=0 and hold_(i-1)=1: register i loads a bubble (all zero).
  - Otherwise register i loads merged stage i-1; stage 0 loads the fetch record, with v=f_valid.
- flush=1: every register loads a bubble next edge, overriding stall. The fetch input is dropped that cycle.
- Commit view comes from merged stage NS-1, combinational, zero added latency.
  - cmt_valid = v.
  - cmt_exc = v & (ev | int_req).
  - Interrupt only when ev=0: code=`exc_int` (0).
  - cmt_epc = bd ? pc-4 : pc (wraps modulo 2^PC_W).
  - cmt_bd = bd.
  - Bubbles never raise exceptions, including on int_req.
- Latency: a fetched record reaches commit NS cycles later with no stalls.
- Intended use: the caller asserts flush on the cycle cmt_exc=1. The block does not self-flush.
- exc_cnt increments on every cycle with cmt_exc=1 and stall[NS-1]=0, and saturates at all-ones.
- Stall at NS-1 with cmt_exc=1: outputs stay stable while held, and the count happens once, on the release cycle.
- Reset mid-operation clears everything asynchronously. The first record may enter on the first edge after release.

Decomposition:
- Shared package/header (extend head.v): `exc_int`=0, `exc_adel`=4, `exc_ades`=5, `exc_ri`=10, `exc_ov`=12; record field widths.
- One sub-module, exc_stage_reg: a single record register with hold/bubble/flush/merge logic. It is instantiated NS times via generate.

Test Plan:
- Reset release, f_valid=1, f_pc=0x3000, no detections, NS=4 -> cmt_valid=1 on the 4th edge with cmt_exc=0; exc_cnt=0.
- f_pc=0x3002 -> on the 4th edge cmt_exc=1, cmt_code=4, cmt_epc=0x3002; det_v[2]=1 with code 12 on the same record is ignored.
- Record at 0x3010 with f_bd=1; det_v[0]=1, code 10 -> cmt_exc=1, cmt_code=10, cmt_bd=1, cmt_epc=0x300C, exc_cnt=1.
- stall[1]=1 for 2 cycles with records A,B,C in flight -> stages 0..1 hold, stage 2 receives 2 bubbles, commit shows 2 cycles with cmt_valid=0, and the order A,B,C is preserved.
- int_req=1 when a bubble is at commit, then when a clean record 0x3020 is at commit -> no exc on the bubble; cmt_exc=1, cmt_code=0, cmt_epc=0x3020.
- flush=1 with stall[3]=1 and 4 valid records -> next edge all v=0. Force exc_cnt to all-ones, then take an exception -> exc_cnt stays all-ones.
